// File: rtl/fsk_serdes_pkg.sv
// Package shared by the FSK word serializer and deserializer.
// It holds the default word width and the FSM state encoding used on both sides of the link.
package fsk_serdes_pkg;

  // Default word width in bits. It is also the number of bit strobes per frame.
  localparam int DATA_SIZE_DEF = 32;

  // Frame FSM states.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/deserializer.sv
// deserializer: collects an LSB-first serial bit stream into DATA_SIZE-bit words.
// Each word is presented on a valid/ack holding register.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   en         bit strobe; din is valid this cycle, held high across a frame
//   din        serial data bit, LSB first
//   data       last completed word, stable while valid=1
//   valid      data holds an unconsumed word
//   ack        consumer accepts data; ignored while valid=0
//   busy       frame reception in progress
//   frame_err  one-cycle pulse when en drops mid-frame
//   overrun    sticky flag: a completed word was dropped (valid=1, ack=0)
module deserializer
  import fsk_serdes_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 din,
  output logic [DATA_SIZE-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_SIZE - 1);

  state_t               state_r, state_nx_s;
  logic [DATA_SIZE-1:0] shreg_r, shreg_nx_s;
  logic [CW-1:0]        cnt_r, cnt_nx_s;
  logic [DATA_SIZE-1:0] word_s;
  logic                 complete_s;
  logic                 abort_s;

  logic [DATA_SIZE-1:0] data_r;
  logic                 valid_r;
  logic                 busy_r;
  logic                 frame_err_r;
  logic                 overrun_r;

  // The incoming bit enters at the MSB, so the first bit of a frame ends up at bit 0.
  assign word_s = {din, shreg_r[DATA_SIZE-1:1]};

  // Next-state, shift and count logic for the frame FSM.
  always_comb begin
    state_nx_s = state_r;
    shreg_nx_s = shreg_r;
    cnt_nx_s   = cnt_r;
    complete_s = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (en) begin
          shreg_nx_s = word_s;
          cnt_nx_s   = CW'(1);
          state_nx_s = S_SHIFT;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (en) begin
          shreg_nx_s = word_s;
          if (cnt_r == LAST_CNT) begin
            // Final bit. Returning to IDLE lets an en=1 in the next cycle start a
            // new frame without a dead cycle.
            complete_s = 1'b1;
            cnt_nx_s   = '0;
            state_nx_s = S_IDLE;
          end else begin
            cnt_nx_s = cnt_r + CW'(1);
          end
        end else begin
          abort_s    = 1'b1;
          shreg_nx_s = '0;
          cnt_nx_s   = '0;
          state_nx_s = S_IDLE;
        end
      end
      default: begin
        shreg_nx_s = '0;
        cnt_nx_s   = '0;
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Shift register, bit counter, FSM state and busy flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_IDLE;
      shreg_r <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      shreg_r <= shreg_nx_s;
      cnt_r   <= cnt_nx_s;
      busy_r  <= (state_nx_s == S_SHIFT);
    end
  end

  // Output holding register with the valid/ack handshake and the error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_r      <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= abort_s;
      if (complete_s) begin
        // An ack in the same cycle frees the register for the new word.
        if (!valid_r || ack) begin
          data_r  <= word_s;
          valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && ack) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_deserializer.sv
// Directed testbench for deserializer: a 32-bit instance and an 8-bit instance.
module tb_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, en = 1'b0, din = 1'b0, ack = 1'b0;
  logic [31:0] data;
  logic        valid, busy, frame_err, overrun;

  logic        rst8 = 1'b0, en8 = 1'b0, din8 = 1'b0, ack8 = 1'b0;
  logic [7:0]  data8;
  logic        valid8, busy8, frame_err8, overrun8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  deserializer #(.DATA_SIZE(32)) dut32 (
    .clk(clk), .rst(rst), .en(en), .din(din), .data(data), .valid(valid),
    .ack(ack), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  deserializer #(.DATA_SIZE(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .din(din8), .data(data8), .valid(valid8),
    .ack(ack8), .busy(busy8), .frame_err(frame_err8), .overrun(overrun8)
  );

  // Advances to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sends a whole 32-bit word LSB first on the 32-bit instance.
  task automatic send_word32(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      en  = 1'b1;
      din = w[i];
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 1'($urandom_range(0, 1));
      tick();
    end
    total_cnt++; if (data !== 32'h0) $display("FAIL reset_data: got %h want %h", data, 32'h0); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
    rst = 1'b1; en = 1'b0; din = 1'b0;
    tick();
  endtask

  task automatic test_single_word;
    logic [31:0] w;
    w = 32'hA5C3_0F81;
    ack = 1'b0;
    for (int i = 0; i < 32; i++) begin
      en  = 1'b1;
      din = w[i];
      tick();
      if (i == 30) begin
        total_cnt++; if (valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else pass_cnt++;
      end
    end
    en = 1'b0;
    total_cnt++; if (valid !== 1'b1) $display("FAIL single_valid: got %b want 1", valid); else pass_cnt++;
    total_cnt++; if (data !== 32'hA5C3_0F81) $display("FAIL single_data: got %h want %h", data, 32'hA5C3_0F81); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_done: got %b want 0", busy); else pass_cnt++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL single_ack_valid: got %b want 0", valid); else pass_cnt++;
    total_cnt++; if (data !== 32'hA5C3_0F81) $display("FAIL single_ack_data: got %h want %h", data, 32'hA5C3_0F81); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] w;
    logic [31:0] got[2];
    int          idx[2];
    int          hits;
    hits = 0;
    ack  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      w   = (i < 32) ? 32'h0000_0001 : 32'h8000_0000;
      en  = 1'b1;
      din = w[i % 32];
      tick();
      if (valid === 1'b1) begin
        if (hits < 2) begin
          idx[hits] = i;
          got[hits] = data;
        end
        hits++;
      end
    end
    en = 1'b0;
    total_cnt++; if (hits !== 2) $display("FAIL b2b_valid_cycles: got %0d want 2", hits); else pass_cnt++;
    if (hits >= 2) begin
      total_cnt++; if (idx[0] !== 31) $display("FAIL b2b_first_latency: got %0d want 31", idx[0]); else pass_cnt++;
      total_cnt++; if (idx[1] - idx[0] !== 32) $display("FAIL b2b_spacing: got %0d want 32", idx[1] - idx[0]); else pass_cnt++;
      total_cnt++; if (got[0] !== 32'h0000_0001) $display("FAIL b2b_word1: got %h want %h", got[0], 32'h0000_0001); else pass_cnt++;
      total_cnt++; if (got[1] !== 32'h8000_0000) $display("FAIL b2b_word2: got %h want %h", got[1], 32'h8000_0000); else pass_cnt++;
    end
    total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else pass_cnt++;
    tick();
    ack = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", valid); else pass_cnt++;
  endtask

  task automatic test_overrun;
    ack = 1'b0;
    send_word32(32'h0000_0001);
    send_word32(32'h8000_0000);
    en = 1'b0;
    total_cnt++; if (data !== 32'h0000_0001) $display("FAIL ovr_data: got %h want %h", data, 32'h0000_0001); else pass_cnt++;
    total_cnt++; if (valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", valid); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else pass_cnt++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b want 0", valid); else pass_cnt++;
    for (int i = 0; i < 4; i++) tick();
    total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_reset_clear: got %b want 0", overrun); else pass_cnt++;
  endtask

  task automatic test_frame_abort;
    ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en  = 1'b1;
      din = 1'b1;
      tick();
    end
    total_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy); else pass_cnt++;
    en = 1'b0;
    tick();
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL abort_pulse: got %b want 1", frame_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", valid); else pass_cnt++;
    tick();
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL abort_pulse_width: got %b want 0", frame_err); else pass_cnt++;
    send_word32(32'hDEAD_BEEF);
    en = 1'b0;
    total_cnt++; if (data !== 32'hDEAD_BEEF) $display("FAIL abort_next_data: got %h want %h", data, 32'hDEAD_BEEF); else pass_cnt++;
    total_cnt++; if (valid !== 1'b1) $display("FAIL abort_next_valid: got %b want 1", valid); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL abort_next_ferr: got %b want 0", frame_err); else pass_cnt++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_trailing_bit;
    send_word32(32'h1234_5678);
    // One extra strobe starts a new frame; dropping en afterwards aborts it.
    en  = 1'b1;
    din = 1'b0;
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL trail_busy: got %b want 1", busy); else pass_cnt++;
    en = 1'b0;
    tick();
    total_cnt++; if (frame_err !== 1'b1) $display("FAIL trail_ferr: got %b want 1", frame_err); else pass_cnt++;
    total_cnt++; if (data !== 32'h1234_5678) $display("FAIL trail_data: got %h want %h", data, 32'h1234_5678); else pass_cnt++;
  endtask

  task automatic test_mid_frame_reset;
    logic [7:0] w;
    int         ferr_seen;
    w = 8'h3C;
    ferr_seen = 0;
    rst8 = 1'b0;
    tick();
    rst8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      en8  = 1'b1;
      din8 = 1'b1;
      tick();
    end
    rst8 = 1'b0;
    tick();
    total_cnt++; if (busy8 !== 1'b0) $display("FAIL mrst_busy: got %b want 0", busy8); else pass_cnt++;
    total_cnt++; if (frame_err8 !== 1'b0) $display("FAIL mrst_ferr: got %b want 0", frame_err8); else pass_cnt++;
    rst8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      en8  = 1'b1;
      din8 = w[i];
      tick();
      if (frame_err8 !== 1'b0) ferr_seen++;
    end
    en8 = 1'b0;
    tick();
    if (frame_err8 !== 1'b0) ferr_seen++;
    total_cnt++; if (data8 !== 8'h3C) $display("FAIL mrst_data: got %h want %h", data8, 8'h3C); else pass_cnt++;
    total_cnt++; if (valid8 !== 1'b1) $display("FAIL mrst_valid: got %b want 1", valid8); else pass_cnt++;
    total_cnt++; if (ferr_seen !== 0) $display("FAIL mrst_no_ferr: got %0d pulses want 0", ferr_seen); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overrun();
    test_frame_abort();
    test_trailing_bit();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
